// File: rtl/traffic_phase_ctrl.sv
// Two-road traffic phase controller: NS/EW greens with yellow and all-red
// clearance, detector-gated green exits and an optional pedestrian walk phase.
//
// Ports:
//   clk, rst (async, active-high), tick (timer time base),
//   ns_detect / ew_detect (vehicle presence, sampled on exit ticks),
//   ns_*/ew_* lamps (registered, one-hot per road),
//   phase (0 NS_G,1 NS_Y,2 AR_NS,3 EW_G,4 EW_Y,5 AR_EW,6 PED),
//   remaining (current timer value).
// Optional feature macro TRAFFIC_PED_EN adds ped_req (in) and walk (out).
module traffic_phase_ctrl #(
  parameter int NS_MIN_GREEN = 32,
  parameter int EW_MIN_GREEN = 16,
  parameter int YELLOW_T     = 4,
  parameter int ALLRED_T     = 1,
  parameter int PED_T        = 8,
  parameter int CNT_W        = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             ns_detect,
  input  logic             ew_detect,
`ifdef TRAFFIC_PED_EN
  input  logic             ped_req,
  output logic             walk,
`endif
  output logic             ns_red,
  output logic             ns_yellow,
  output logic             ns_green,
  output logic             ew_red,
  output logic             ew_yellow,
  output logic             ew_green,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] remaining
);

  localparam logic [2:0] S_NSG  = 3'd0;
  localparam logic [2:0] S_NSY  = 3'd1;
  localparam logic [2:0] S_ARNS = 3'd2;
  localparam logic [2:0] S_EWG  = 3'd3;
  localparam logic [2:0] S_EWY  = 3'd4;
  localparam logic [2:0] S_AREW = 3'd5;
  localparam logic [2:0] S_PED  = 3'd6;

  localparam logic [CNT_W-1:0] LD_NSG = CNT_W'(NS_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] LD_EWG = CNT_W'(EW_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] LD_Y   = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] LD_AR  = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] LD_PED = CNT_W'(PED_T - 1);

  // Timer reload value for the state being entered.
  function automatic logic [CNT_W-1:0] load_of(input logic [2:0] s);
    case (s)
      S_NSG:         load_of = LD_NSG;
      S_EWG:         load_of = LD_EWG;
      S_NSY, S_EWY:  load_of = LD_Y;
      S_ARNS,
      S_AREW:        load_of = LD_AR;
      default:       load_of = LD_PED;
    endcase
  endfunction

  // Lamp pattern {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g}.
  function automatic logic [5:0] lamps_of(input logic [2:0] s);
    case (s)
      S_NSG:   lamps_of = 6'b001_100;
      S_NSY:   lamps_of = 6'b010_100;
      S_EWG:   lamps_of = 6'b100_001;
      S_EWY:   lamps_of = 6'b100_010;
      default: lamps_of = 6'b100_100;
    endcase
  endfunction

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       lamp_q;

`ifdef TRAFFIC_PED_EN
  logic ped_q, ped_d;
  // after_q: 1 when EW_G follows the walk phase, 0 when NS_G does.
  logic after_q, after_d;
  logic walk_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef TRAFFIC_PED_EN
    after_d = after_q;
`endif
    if (tick) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        case (state_q)
          S_NSG:  if (ew_detect) state_d = S_NSY;
          S_NSY:  state_d = S_ARNS;
          S_ARNS: begin
            state_d = S_EWG;
`ifdef TRAFFIC_PED_EN
            if (ped_q) begin
              state_d = S_PED;
              after_d = 1'b1;
            end
`endif
          end
          S_EWG:  if (ns_detect || !ew_detect) state_d = S_EWY;
          S_EWY:  state_d = S_AREW;
          S_AREW: begin
            state_d = S_NSG;
`ifdef TRAFFIC_PED_EN
            if (ped_q) begin
              state_d = S_PED;
              after_d = 1'b0;
            end
`endif
          end
`ifdef TRAFFIC_PED_EN
          S_PED:  state_d = after_q ? S_EWG : S_NSG;
`endif
          default: state_d = S_NSG;
        endcase
        if (state_d != state_q) cnt_d = load_of(state_d);
      end
    end
  end

`ifdef TRAFFIC_PED_EN
  // A request in the PED entry cycle survives the clear.
  always_comb begin
    ped_d = ped_q;
    if (state_d == S_PED && state_q != S_PED) ped_d = 1'b0;
    if (ped_req) ped_d = 1'b1;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_NSG;
      cnt_q   <= LD_NSG;
      lamp_q  <= lamps_of(S_NSG);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lamp_q  <= lamps_of(state_d);
    end
  end

`ifdef TRAFFIC_PED_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ped_q   <= 1'b0;
      after_q <= 1'b0;
      walk_q  <= 1'b0;
    end else begin
      ped_q   <= ped_d;
      after_q <= after_d;
      walk_q  <= (state_d == S_PED);
    end
  end

  assign walk = walk_q;
`endif

  assign {ns_red, ns_yellow, ns_green} = lamp_q[5:3];
  assign {ew_red, ew_yellow, ew_green} = lamp_q[2:0];
  assign phase     = state_q;
  assign remaining = cnt_q;

endmodule
